// File: rtl/mfp_ahb_boot_loader_if.sv
// rtl/mfp_ahb_boot_loader_if.sv - AHB-Lite write-master signal bundle used by the boot loader
interface mfp_ahb_boot_loader_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HREADY;

    modport master (
        output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        input  HREADY
    );

    modport slave (
        input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
        output HREADY
    );
endinterface

// File: rtl/mfp_ahb_boot_loader.sv
// rtl/mfp_ahb_boot_loader.sv - byte-stream to AHB-Lite word writer; optional checksum via MFP_BOOT_LOADER_CHECKSUM_EN
module mfp_ahb_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h1FC0_0000,
    parameter int unsigned NUM_WORDS = 1024
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic                         start,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    mfp_ahb_boot_loader_if.master        ahb,
    output logic                         busy,
    output logic                         done
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]                  checksum
`endif
);

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [16:0] LAST_WORD     = 17'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [16:0] word_cnt_q, word_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] haddr_q, haddr_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    // Next-state and next-output computation; every output is a flop so the bus sees glitch-free values
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        haddr_d    = haddr_q;
        hwdata_d   = hwdata_q;
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_COLLECT;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
                    csum_d     = '0;
`endif
                end
            end
            S_COLLECT: begin
                if (in_valid && in_ready_q) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_ADDR;
                        haddr_d = BASE_ADDR + {13'b0, word_cnt_q, 2'b00};
                    end
                end
            end
            S_ADDR: begin
                if (ahb.HREADY) begin
                    state_d  = S_DATA;
                    hwdata_d = word_q;
                end
            end
            S_DATA: begin
                if (ahb.HREADY) begin
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
                    csum_d = csum_q + hwdata_q;
`endif
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_COLLECT;
                        word_cnt_d = word_cnt_q + 17'd1;
                        byte_cnt_d = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_COLLECT);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        htrans_d   = (state_d == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        hwrite_d   = (state_d == S_ADDR);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            haddr_q    <= BASE_ADDR;
            hwdata_q   <= '0;
            htrans_q   <= HTRANS_IDLE;
            hwrite_q   <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            haddr_q    <= haddr_d;
            hwdata_q   <= hwdata_d;
            htrans_q   <= htrans_d;
            hwrite_q   <= hwrite_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign ahb.HADDR     = haddr_q;
    assign ahb.HWDATA    = hwdata_q;
    assign ahb.HTRANS    = htrans_q;
    assign ahb.HWRITE    = hwrite_q;
    assign ahb.HBURST    = 3'b000;
    assign ahb.HMASTLOCK = 1'b0;
    assign ahb.HPROT     = 4'b0011;
    assign ahb.HSIZE     = 3'b010;
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
    assign checksum      = csum_q;
`endif

endmodule

// File: tb/tb_mfp_ahb_boot_loader.sv
// tb/tb_mfp_ahb_boot_loader.sv - scoreboard bench for mfp_ahb_boot_loader
`timescale 1ns/1ps
module tb_mfp_ahb_boot_loader;
    localparam logic [31:0] BASE = 32'h1FC0_0000;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       busy;
    logic       done;
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    mfp_ahb_boot_loader_if ahb ();

    mfp_ahb_boot_loader #(
        .BASE_ADDR(BASE),
        .NUM_WORDS(2)
    ) dut (
        .HCLK(HCLK),
        .HRESETn(HRESETn),
        .start(start),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ahb(ahb),
        .busy(busy),
        .done(done)
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          lat;
        logic [31:0] csum;
    } dn_t;

    wr_t exp_wr[$];
    dn_t exp_dn[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int addr_stall = 0;
    int data_stall = 0;
    int done_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge HCLK) cyc <= cyc + 1;

    bit          dphase = 0;
    int          a_cnt = 0;
    int          d_cnt = 0;
    int          ns_cnt = 0;
    logic [31:0] wd_first = '0;
    bit          got_first = 0;
    int          first_cyc = 0;
    bit          done_prev = 0;
    wr_t         cur;
    dn_t         dn;

    // Slave model and monitor: decides HREADY for the coming edge and checks what the DUT presents
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dphase     = 0;
            a_cnt      = 0;
            d_cnt      = 0;
            ns_cnt     = 0;
            got_first  = 0;
            done_prev  = 0;
            ahb.HREADY = 1'b1;
        end else begin
            if (in_valid && in_ready && !got_first) begin
                got_first = 1;
                first_cyc = cyc;
            end
            if (done_prev) check("done_one_cycle", {31'b0, done}, 32'd0);
            done_prev = done;
            if (done) begin
                done_seen++;
                if (exp_dn.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    dn = exp_dn.pop_front();
                    if (dn.lat >= 0) check("done_latency", 32'(cyc - first_cyc), 32'(dn.lat));
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
                    check("checksum", checksum, dn.csum);
`endif
                end
                got_first = 0;
            end
            if (ahb.HTRANS == 2'b10) begin
                ns_cnt++;
                if (a_cnt < addr_stall) begin
                    ahb.HREADY = 1'b0;
                    a_cnt++;
                end else begin
                    ahb.HREADY = 1'b1;
                    a_cnt = 0;
                    check("nonseq_hold", 32'(ns_cnt), 32'(addr_stall + 1));
                    ns_cnt = 0;
                    check("hwrite_addr", {31'b0, ahb.HWRITE}, 32'd1);
                    if (exp_wr.size() == 0) begin
                        check("unexpected_write", 32'd1, 32'd0);
                        cur.addr = 'x;
                        cur.data = 'x;
                    end else begin
                        cur = exp_wr.pop_front();
                        check("haddr", ahb.HADDR, cur.addr);
                    end
                    dphase = 1;
                    d_cnt  = 0;
                end
            end else if (dphase) begin
                if (d_cnt == 0) wd_first = ahb.HWDATA;
                else check("hwdata_stable", ahb.HWDATA, wd_first);
                if (d_cnt < data_stall) begin
                    ahb.HREADY = 1'b0;
                    d_cnt++;
                end else begin
                    ahb.HREADY = 1'b1;
                    check("hwdata", ahb.HWDATA, cur.data);
                    check("hwrite_data", {31'b0, ahb.HWRITE}, 32'd0);
                    dphase = 0;
                    d_cnt  = 0;
                end
            end else begin
                ahb.HREADY = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t = 0;
        if (gap) begin
            in_valid = 1'b0;
            tick(1);
        end
        in_data  = b;
        in_valid = 1'b1;
        @(negedge HCLK);
        while (!in_ready && t < 100) begin
            t++;
            @(negedge HCLK);
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge HCLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        int base = done_seen;
        while (done_seen == base && t < 300) begin
            tick(1);
            t++;
        end
        if (done_seen == base) check("done_timeout", 32'd0, 32'd1);
        tick(2);
    endtask

    task automatic expect_load(input logic [63:0] img, input int lat);
        exp_wr.push_back('{BASE, img[31:0]});
        exp_wr.push_back('{BASE + 32'd4, img[63:32]});
        exp_dn.push_back('{lat, img[31:0] + img[63:32]});
    endtask

    task automatic run_load(input logic [63:0] img, input bit gap, input int lat);
        expect_load(img, lat);
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(img[8*i +: 8], gap);
        wait_done();
    endtask

    task automatic check_reset_vals();
        check("rst_htrans", {30'b0, ahb.HTRANS}, 32'd0);
        check("rst_hwrite", {31'b0, ahb.HWRITE}, 32'd0);
        check("rst_haddr", ahb.HADDR, BASE);
        check("rst_hwdata", ahb.HWDATA, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
`ifdef MFP_BOOT_LOADER_CHECKSUM_EN
        check("rst_checksum", checksum, 32'd0);
`endif
    endtask

    initial begin
        logic [63:0] img;
        ahb.HREADY = 1'b1;
        HRESETn = 1'b0;
        tick(3);
        check_reset_vals();
        check("hburst", {29'b0, ahb.HBURST}, 32'd0);
        check("hmastlock", {31'b0, ahb.HMASTLOCK}, 32'd0);
        check("hprot", {28'b0, ahb.HPROT}, 32'h3);
        check("hsize", {29'b0, ahb.HSIZE}, 32'h2);
        HRESETn = 1'b1;
        tick(2);

        // Back-to-back bytes, HREADY always high, done latency 12
        run_load(64'h08070605_04030201, 1'b0, 12);

        // Address phase stalled 3 cycles, data phase stalled 2
        addr_stall = 3;
        data_stall = 2;
        run_load(64'h18171615_14131211, 1'b0, -1);
        addr_stall = 0;
        data_stall = 0;

        // in_valid toggling each cycle
        run_load(64'h08070605_04030201, 1'b1, -1);

        // start pulsed while busy is ignored
        img = 64'h28272625_24232221;
        expect_load(img, -1);
        pulse_start();
        send_byte(img[7:0], 1'b0);
        send_byte(img[15:8], 1'b0);
        pulse_start();
        send_byte(img[23:16], 1'b0);
        send_byte(img[31:24], 1'b0);
        pulse_start();
        for (int i = 4; i < 8; i++) send_byte(img[8*i +: 8], 1'b0);
        wait_done();

        // Reset after two bytes of word 1 abandons the load
        exp_wr.push_back('{BASE, 32'h44434241});
        pulse_start();
        send_byte(8'h41, 1'b0);
        send_byte(8'h42, 1'b0);
        send_byte(8'h43, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h45, 1'b0);
        send_byte(8'h46, 1'b0);
        HRESETn = 1'b0;
        tick(1);
        check_reset_vals();
        HRESETn = 1'b1;
        tick(10);
        check("writes_after_reset", 32'(exp_wr.size()), 32'd0);
        run_load(64'hB4B3B2B1_A4A3A2A1, 1'b0, 12);

        // Checksum wrap: FFFFFFFF + 00000002
        run_load(64'h00000002_FFFFFFFF, 1'b0, 12);

        tick(5);
        check("writes_pending", 32'(exp_wr.size()), 32'd0);
        check("done_pending", 32'(exp_dn.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mfp_ahb_boot_loader.md
MFP_AHB_BOOT_LOADER -- requirements
Module: mfp_ahb_boot_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1FC0_0000, byte address of the first word written; bits [1:0] SHALL be zero.
REQ-002 Parameter NUM_WORDS, default 1024, number of 32-bit words per load, legal range 1..65536.
REQ-003 HCLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 HRESETn  in  1  reset, synchronous and active-low.
REQ-005 start  in  1  single-cycle load request.
REQ-006 in_data  in  8  boot image byte.
REQ-007 in_valid  in  1  in_data valid.
REQ-008 in_ready  out  1  byte accepted when in_valid & in_ready at a rising edge.
REQ-009 HADDR  out  32  AHB-Lite master address.
REQ-010 HBURST  out  3  constant 3'b000 (SINGLE).
REQ-011 HMASTLOCK  out  1  constant 0.
REQ-012 HPROT  out  4  constant 4'b0011.
REQ-013 HSIZE  out  3  constant 3'b010 (word).
REQ-014 HTRANS  out  2  2'b00 IDLE or 2'b10 NONSEQ only.
REQ-015 HWDATA  out  32  write data.
REQ-016 HWRITE  out  1  write strobe.
REQ-017 HREADY  in  1  transfer-complete/stall from the interconnect.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse after the last word's data phase completes.

Function
REQ-020 FSM states SHALL be IDLE, COLLECT, ADDR, DATA, DONE.
REQ-021 IDLE: start=1 -> COLLECT, word counter := 0, byte counter := 0; start outside IDLE SHALL be ignored.
REQ-022 COLLECT: in_ready=1; each accepted byte SHALL go to word lane [8*k+7:8*k], k = byte counter (first byte -> [7:0], little-endian).
REQ-023 The 4th accepted byte SHALL move FSM to ADDR on the same edge; in_ready SHALL be 0 in all other states.
REQ-024 ADDR: HTRANS=NONSEQ, HWRITE=1, HADDR = BASE_ADDR + 4*word counter (32-bit wrap); state held while HREADY=0, -> DATA when HREADY=1.
REQ-025 DATA: HTRANS=IDLE, HWRITE=0, HWDATA = assembled word, held stable until HREADY=1.
REQ-026 DATA with HREADY=1: word counter = NUM_WORDS-1 -> DONE, else -> COLLECT with word counter +1, byte counter 0.
REQ-027 DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-028 Minimum per-word latency with HREADY=1 and in_valid=1 every cycle: 4 COLLECT cycles + 1 ADDR + 1 DATA = 6 cycles.
REQ-029 HWDATA SHALL hold its last value outside DATA; HADDR SHALL hold its last value outside ADDR.
REQ-030 in_valid deasserted mid-word SHALL stall assembly with no byte lost or duplicated.

Reset
REQ-031 HRESETn=0 at a rising edge: state IDLE, counters 0, HTRANS=IDLE, HWRITE=0, HADDR=BASE_ADDR, HWDATA=0, in_ready=0, busy=0, done=0.
REQ-032 Reset mid-load SHALL abandon the load: partial word discarded, no further transfers issued, done not pulsed.

Configuration
REQ-033 Macro MFP_BOOT_LOADER_CHECKSUM_EN defined: extra output checksum[31:0] SHALL equal the modulo-2^32 sum of all words written since the last start, cleared to 0 on start and reset, final value valid when done=1.
REQ-034 Macro undefined: the checksum port and its adder SHALL not exist; all other behaviour identical.

Verification
REQ-035 NUM_WORDS=2, HREADY=1, bytes 01 02 03 04 05 06 07 08 streamed -> writes 32'h04030201 @BASE_ADDR, 32'h08070605 @BASE_ADDR+4, done pulse 12 cycles after the first byte is accepted.
REQ-036 HREADY=0 for 3 cycles in ADDR, then 2 in DATA -> NONSEQ held 4 cycles, HWDATA stable throughout, exactly one write per word.
REQ-037 in_valid toggling 1/0 each cycle -> identical data and addresses to REQ-035, no lost or duplicate bytes.
REQ-038 start pulsed while busy -> ignored; counters and addresses unaffected.
REQ-039 HRESETn=0 after 2 bytes of word 1 -> all outputs at REQ-031 values next cycle; restart writes word 0 at BASE_ADDR.
REQ-040 With MFP_BOOT_LOADER_CHECKSUM_EN, words FFFFFFFF and 00000002 -> checksum 32'h00000001 at done.
